// File: rtl/canny_window_driver.sv
// canny_window_driver: loads a 5x5 window (up to three planes) from the window
// buffer into the Canny detector, runs one operation, reads the result back.
//
// state | meaning
// IDLE  | bus idle, waiting for start
// LOAD  | stream window bytes buffer -> detector, one per cycle
// OP    | bOPEnable low for OP_CYCLES cycles
// RD1   | read primary result register
// RD2   | capture primary result; Sobel also reads direction
// FIN   | capture direction, publish results and done
module canny_window_driver #(
  parameter int OP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] cmd_mode,
  input  logic [2:0] cmd_planes,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] result_a,
  output logic [7:0] result_b,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic [2:0] dAddrRegRow,
  output logic [2:0] dAddrRegCol,
  output logic       bWE,
  output logic       bCE,
  output logic [7:0] InData,
  input  logic [7:0] OutData,
  output logic [2:0] OPMode,
  output logic       bOPEnable,
  output logic [3:0] dReadReg,
  output logic [3:0] dWriteReg
);

  typedef enum logic [2:0] {IDLE, LOAD, OP, RD1, RD2, FIN} state_t;

  localparam int CW = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
  localparam logic [CW-1:0] OP_LAST = CW'(OP_CYCLES - 1);

  localparam logic [1:0] M_GAUSS = 2'd0;
  localparam logic [1:0] M_SOBEL = 2'd1;
  localparam logic [1:0] M_NMS   = 2'd2;
  localparam logic [1:0] M_HYST  = 2'd3;

  state_t          state, stateNext;
  logic [1:0]      modeQ;
  logic            errQ;
  logic [2:0]      issMask;
  logic [2:0]      issRow, issCol;
  logic [1:0]      issPlane;
  logic            issuing;
  logic            wrValid;
  logic [1:0]      wrPlane;
  logic [2:0]      wrRow, wrCol;
  logic [CW-1:0]   opCnt;
  logic [7:0]      holdA;

  assign issuing = (state == LOAD) && (issMask != 3'b000);

  // Plane currently being issued: lowest remaining bit of the load mask.
  always_comb begin
    issPlane = 2'd2;
    if (issMask[0])      issPlane = 2'd0;
    else if (issMask[1]) issPlane = 2'd1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Command latch, address walker, write pipeline, op timer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      modeQ    <= 2'd0;
      errQ     <= 1'b0;
      issMask  <= 3'b000;
      issRow   <= 3'd0;
      issCol   <= 3'd0;
      wrValid  <= 1'b0;
      wrPlane  <= 2'd0;
      wrRow    <= 3'd0;
      wrCol    <= 3'd0;
      opCnt    <= OP_LAST;
      holdA    <= 8'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      result_a <= 8'd0;
      result_b <= 8'd0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      // buffer data returns one cycle after the address, so the write side lags by one
      wrValid <= issuing;
      wrPlane <= issPlane;
      wrRow   <= issRow;
      wrCol   <= issCol;
      if (state != OP)       opCnt <= OP_LAST;
      else if (opCnt != '0)  opCnt <= opCnt - 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            errQ   <= cmd_mode[2];
            issRow <= 3'd0;
            issCol <= 3'd0;
            if (!cmd_mode[2]) begin
              modeQ   <= cmd_mode[1:0];
              issMask <= cmd_planes;
            end
          end
        end
        LOAD: begin
          if (issuing) begin
            if (issCol == 3'd4) begin
              issCol <= 3'd0;
              if (issRow == 3'd4) begin
                issRow  <= 3'd0;
                issMask <= issMask & (issMask - 3'd1);
              end else begin
                issRow <= issRow + 3'd1;
              end
            end else begin
              issCol <= issCol + 3'd1;
            end
          end
        end
        RD2: holdA <= OutData;
        FIN: begin
          done     <= 1'b1;
          err      <= errQ;
          result_a <= errQ ? 8'd0 : holdA;
          result_b <= (!errQ && modeQ == M_SOBEL) ? OutData : 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and detector bus drive.
  always_comb begin
    stateNext   = state;
    busy        = (state != IDLE);
    mem_addr    = 8'd0;
    bCE         = 1'b1;
    bWE         = 1'b1;
    bOPEnable   = 1'b1;
    InData      = 8'd0;
    dAddrRegRow = 3'd0;
    dAddrRegCol = 3'd0;
    OPMode      = 3'd0;
    dReadReg    = 4'd0;
    dWriteReg   = 4'd0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cmd_mode[2])               stateNext = FIN;
          else if (cmd_planes == 3'b000) stateNext = OP;
          else                           stateNext = LOAD;
        end
      end
      LOAD: begin
        if (issuing) mem_addr = {issPlane, issRow, issCol};
        if (wrValid) begin
          bCE         = 1'b0;
          bWE         = 1'b0;
          InData      = mem_data;
          dAddrRegRow = wrRow;
          dAddrRegCol = wrCol;
          dWriteReg   = {2'b00, wrPlane};
        end
        if (!issuing) stateNext = OP;
      end
      OP: begin
        bOPEnable = 1'b0;
        OPMode    = {1'b0, modeQ};
        if (opCnt == '0) stateNext = RD1;
      end
      RD1: begin
        bCE = 1'b0;
        case (modeQ)
          M_GAUSS: dReadReg = 4'd0;
          M_SOBEL: dReadReg = 4'd1;
          M_NMS: begin
            dReadReg    = 4'd3;
            dAddrRegRow = 3'd1;
            dAddrRegCol = 3'd1;
          end
          M_HYST:  dReadReg = 4'd4;
          default: dReadReg = 4'd0;
        endcase
        stateNext = RD2;
      end
      RD2: begin
        if (modeQ == M_SOBEL) begin
          bCE      = 1'b0;
          dReadReg = 4'd2;
        end
        stateNext = FIN;
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_canny_window_driver.sv
// Bench for canny_window_driver: behavioural window buffer and detector,
// bus monitor logging absolute cycles, directed and randomized commands.
module tb_canny_window_driver;
  localparam int OPC = 4;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] cmd_mode, cmd_planes;
  logic       busy, done, err;
  logic [7:0] result_a, result_b, mem_addr, mem_data, InData, OutData;
  logic [2:0] dAddrRegRow, dAddrRegCol, OPMode;
  logic       bWE, bCE, bOPEnable;
  logic [3:0] dReadReg, dWriteReg;

  always #5 clk = ~clk;

  canny_window_driver #(.OP_CYCLES(OPC)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_mode(cmd_mode), .cmd_planes(cmd_planes),
    .busy(busy), .done(done), .err(err), .result_a(result_a), .result_b(result_b),
    .mem_addr(mem_addr), .mem_data(mem_data), .dAddrRegRow(dAddrRegRow),
    .dAddrRegCol(dAddrRegCol), .bWE(bWE), .bCE(bCE), .InData(InData), .OutData(OutData),
    .OPMode(OPMode), .bOPEnable(bOPEnable), .dReadReg(dReadReg), .dWriteReg(dWriteReg)
  );

  logic [7:0] mem [256];
  logic [7:0] detRegs [3][5][5];
  logic [7:0] refRegs [3][5][5];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; int wreg; int row; int col; int data; } wr_t;
  typedef struct { int cyc; int rreg; int row; int col; } rd_t;
  wr_t wrLog[$];
  rd_t rdLog[$];
  int doneCount = 0, opLow = 0, bceLow = 0, resChg = 0, opModeSeen = 0;
  int lastDoneCyc = 0, busyRiseCyc = 0, busyFallCyc = 0;
  logic lastErr = 1'b0, prevBusy = 1'b0;
  logic [7:0] lastA = 8'd0, lastB = 8'd0, prevA = 8'd0, prevB = 8'd0;

  int t0, baseWr, baseRd, baseDone, baseOp, baseBce, baseChg;

  // Detector response computed from a register image (bus-loaded or reference).
  function automatic logic [7:0] det_read(input bit useRef, input int sel, input int r, input int c);
    int x[5][5];
    int y22, sum, g, a, b;
    bit ok;
    logic [7:0] res;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        x[i][j] = useRef ? int'(refRegs[0][i][j]) : int'(detRegs[0][i][j]);
    y22 = useRef ? int'(refRegs[1][2][2]) : int'(detRegs[1][2][2]);
    res = 8'hFF;
    case (sel)
      0: begin
        sum = 0;
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) sum += x[i][j];
        res = 8'(sum / 25);
      end
      1: begin
        a = x[2][3] - x[2][1]; if (a < 0) a = -a;
        b = x[3][2] - x[1][2]; if (b < 0) b = -b;
        g = a + b;
        res = (g > 255) ? 8'd255 : 8'(g);
      end
      2: res = {6'b0, x[2][3] > x[2][1], x[3][2] > x[1][2]};
      3: begin
        if (r == 1 && c == 1) begin
          ok = 1'b1;
          for (int i = 1; i < 4; i++) for (int j = 1; j < 4; j++) if (x[i][j] > x[2][2]) ok = 1'b0;
          res = ok ? 8'(x[2][2]) : 8'd0;
        end else res = 8'hEE;
      end
      4: res = (x[2][2] > y22) ? 8'd1 : 8'd0;
      default: res = 8'hFF;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] exp_a(input int mode);
    int sel;
    sel = (mode == 0) ? 0 : (mode == 1) ? 1 : (mode == 2) ? 3 : 4;
    return det_read(1'b1, sel, (mode == 2) ? 1 : 0, (mode == 2) ? 1 : 0);
  endfunction

  function automatic logic [7:0] exp_b(input int mode);
    return (mode == 1) ? det_read(1'b1, 2, 0, 0) : 8'd0;
  endfunction

  function automatic int exp_done(input int mode, input logic [2:0] mask);
    int n;
    n = $countones(mask);
    if (mode > 3) return 2;
    return (n == 0) ? OPC + 4 : 25 * n + OPC + 5;
  endfunction

  // Number of differences between the logged writes and the expected X,Y,Z row-major stream.
  function automatic int wr_mismatch(input logic [2:0] mask);
    int k, bad, idx;
    wr_t e;
    k = 0; bad = 0;
    for (int p = 0; p < 3; p++) if (mask[p])
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) begin
        idx = baseWr + k;
        if (idx >= wrLog.size()) bad++;
        else begin
          e = wrLog[idx];
          if (e.cyc != t0 + 2 + k || e.wreg != p || e.row != r || e.col != c ||
              e.data != int'(mem[p * 64 + r * 8 + c])) bad++;
        end
        k++;
      end
    if (wrLog.size() - baseWr != k) bad++;
    return bad;
  endfunction

  task automatic ref_load(input logic [2:0] mask);
    for (int p = 0; p < 3; p++) if (mask[p])
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++)
        refRegs[p][r][c] = mem[p * 64 + r * 8 + c];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  // Window buffer: one-cycle read latency.
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Detector: register writes and registered reads.
  always @(posedge clk) begin
    if (rst && cyc < 5) begin
      OutData <= 8'd0;
      for (int p = 0; p < 3; p++) for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++)
        detRegs[p][r][c] <= 8'd0;
    end else begin
      if (!bCE && !bWE && dWriteReg < 4'd3 && dAddrRegRow < 3'd5 && dAddrRegCol < 3'd5)
        detRegs[int'(dWriteReg)][int'(dAddrRegRow)][int'(dAddrRegCol)] <= InData;
      if (!bCE && bWE)
        OutData <= det_read(1'b0, int'(dReadReg), int'(dAddrRegRow), int'(dAddrRegCol));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!bCE && !bWE) wrLog.push_back('{cyc, int'(dWriteReg), int'(dAddrRegRow), int'(dAddrRegCol), int'(InData)});
    if (!bCE && bWE)  rdLog.push_back('{cyc, int'(dReadReg), int'(dAddrRegRow), int'(dAddrRegCol)});
    if (!bCE) bceLow++;
    if (!bOPEnable) begin opLow++; opModeSeen = int'(OPMode); end
    if (done) begin doneCount++; lastDoneCyc = cyc; lastErr = err; lastA = result_a; lastB = result_b; end
    if (busy && !prevBusy) busyRiseCyc = cyc;
    if (!busy && prevBusy) busyFallCyc = cyc;
    if (!done && (result_a !== prevA || result_b !== prevB)) resChg++;
    prevBusy = busy; prevA = result_a; prevB = result_b;
  end

  // Issue one command at the current falling edge and wait for done (bounded).
  task automatic drive_cmd(input logic [2:0] mode, input logic [2:0] planes, input int injectAt);
    int n;
    baseWr = wrLog.size(); baseRd = rdLog.size(); baseDone = doneCount;
    baseOp = opLow; baseBce = bceLow; baseChg = resChg;
    cmd_mode = mode; cmd_planes = planes; start = 1'b1; t0 = cyc;
    n = 0;
    do begin
      @(negedge clk); n++;
      start = (cyc - t0 == injectAt);
      if (start) begin cmd_mode = 3'd3; cmd_planes = 3'd7; end
    end while (doneCount == baseDone && n < 400);
    start = 1'b0;
    checks++; if (doneCount == baseDone) begin failures++; $display("FAIL done_timeout: no done after %0d cycles, want one", n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cmd_mode = 3'd0; cmd_planes = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done, err, bCE, bWE, bOPEnable} !== 6'b000111) begin failures++; $display("FAIL reset_ctrl: got %b want 000111", {busy, done, err, bCE, bWE, bOPEnable}); end
    checks++; if ({result_a, result_b, mem_addr, InData, OPMode, dReadReg, dWriteReg, dAddrRegRow, dAddrRegCol} !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", {result_a, result_b, mem_addr, InData, OPMode, dReadReg, dWriteReg}); end
  endtask

  task automatic test_gaussian();
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 8'd128;
    @(negedge clk);
    drive_cmd(3'd0, 3'b001, -1);
    ref_load(3'b001);
    bad = wr_mismatch(3'b001);
    checks++; if (bad !== 0) begin failures++; $display("FAIL gauss_writes: got %0d bad writes want 0", bad); end
    checks++; if (lastDoneCyc - t0 !== 34) begin failures++; $display("FAIL gauss_done_cycle: got %0d want 34", lastDoneCyc - t0); end
    checks++; if (lastA !== exp_a(0) || lastA !== 8'd128) begin failures++; $display("FAIL gauss_result: got %0d want 128", lastA); end
    checks++; if (lastErr !== 1'b0) begin failures++; $display("FAIL gauss_err: got %b want 0", lastErr); end
    checks++; if (busyRiseCyc - t0 !== 1 || busyFallCyc - t0 !== 34) begin failures++; $display("FAIL gauss_busy: got rise %0d fall %0d want 1 34", busyRiseCyc - t0, busyFallCyc - t0); end
    checks++; if (opLow - baseOp !== OPC || opModeSeen !== 0) begin failures++; $display("FAIL gauss_op: got %0d cycles mode %0d want %0d 0", opLow - baseOp, opModeSeen, OPC); end
    repeat (2) @(negedge clk);
    checks++; if (doneCount - baseDone !== 1) begin failures++; $display("FAIL gauss_done_width: got %0d pulses want 1", doneCount - baseDone); end
  endtask

  task automatic test_sobel();
    int d;
    for (int i = 0; i < 256; i++) mem[i] = 8'd50;
    @(negedge clk);
    drive_cmd(3'd1, 3'b001, -1);
    ref_load(3'b001);
    d = lastDoneCyc - t0;
    checks++; if (rdLog.size() - baseRd !== 2) begin failures++; $display("FAIL sobel_nreads: got %0d want 2", rdLog.size() - baseRd); end
    else begin
      checks++; if (rdLog[baseRd].rreg !== 1 || rdLog[baseRd].cyc - t0 !== d - 3) begin failures++; $display("FAIL sobel_rd1: got reg %0d cyc %0d want 1 %0d", rdLog[baseRd].rreg, rdLog[baseRd].cyc - t0, d - 3); end
      checks++; if (rdLog[baseRd + 1].rreg !== 2 || rdLog[baseRd + 1].cyc - t0 !== d - 2) begin failures++; $display("FAIL sobel_rd2: got reg %0d cyc %0d want 2 %0d", rdLog[baseRd + 1].rreg, rdLog[baseRd + 1].cyc - t0, d - 2); end
    end
    checks++; if (lastA !== exp_a(1) || lastB !== exp_b(1)) begin failures++; $display("FAIL sobel_result: got %0d/%0d want %0d/%0d", lastA, lastB, exp_a(1), exp_b(1)); end
  endtask

  task automatic test_hysteresis();
    int bad;
    fill_random();
    mem[18] = 8'd20; mem[64 + 18] = 8'd0;
    @(negedge clk);
    drive_cmd(3'd3, 3'b111, -1);
    ref_load(3'b111);
    bad = wr_mismatch(3'b111);
    checks++; if (bad !== 0) begin failures++; $display("FAIL hyst_writes: got %0d bad writes want 0", bad); end
    checks++; if (lastDoneCyc - t0 !== 84) begin failures++; $display("FAIL hyst_done_cycle: got %0d want 84", lastDoneCyc - t0); end
    checks++; if (lastA !== exp_a(3) || lastA !== 8'd1) begin failures++; $display("FAIL hyst_result: got %0d want 1", lastA); end
  endtask

  task automatic test_nms();
    fill_random();
    for (int r = 1; r < 4; r++) for (int c = 1; c < 4; c++) mem[r * 8 + c] = 8'd10;
    mem[18] = 8'd30; mem[64 + 18] = 8'd0;
    @(negedge clk);
    drive_cmd(3'd2, 3'b011, -1);
    ref_load(3'b011);
    checks++; if (rdLog.size() - baseRd !== 1 || rdLog[baseRd].rreg !== 3 || rdLog[baseRd].row !== 1 || rdLog[baseRd].col !== 1) begin failures++; $display("FAIL nms_read: got %0d reads reg %0d want 1 read reg 3 at 1/1", rdLog.size() - baseRd, rdLog[baseRd].rreg); end
    checks++; if (lastA !== exp_a(2) || lastA !== 8'd30) begin failures++; $display("FAIL nms_result: got %0d want 30", lastA); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    drive_cmd(3'd5, 3'b111, -1);
    checks++; if (lastDoneCyc - t0 !== 2 || lastErr !== 1'b1) begin failures++; $display("FAIL illegal_done: got cyc %0d err %b want 2 1", lastDoneCyc - t0, lastErr); end
    checks++; if (bceLow - baseBce !== 0 || wrLog.size() - baseWr !== 0) begin failures++; $display("FAIL illegal_bus: got %0d bCE-low cycles want 0", bceLow - baseBce); end
  endtask

  task automatic test_robust();
    logic [2:0] m;
    fill_random();
    @(negedge clk);
    baseDone = doneCount;
    cmd_mode = 3'd0; cmd_planes = 3'b111; start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, err, bCE, bWE, bOPEnable} !== 6'b000111 || {mem_addr, InData, OPMode, dReadReg, dWriteReg, result_a, result_b} !== '0) begin failures++; $display("FAIL abort_reset: got ctrl %b addr %h want 000111 0", {busy, done, err, bCE, bWE, bOPEnable}, mem_addr); end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (doneCount !== baseDone) begin failures++; $display("FAIL abort_nodone: got %0d pulses want 0", doneCount - baseDone); end
    fill_random();
    drive_cmd(3'd1, 3'b001, 28);
    ref_load(3'b001);
    checks++; if (lastDoneCyc - t0 !== 34 || lastA !== exp_a(1) || lastB !== exp_b(1)) begin failures++; $display("FAIL busy_start_cmd: got cyc %0d res %0d/%0d want 34 %0d/%0d", lastDoneCyc - t0, lastA, lastB, exp_a(1), exp_b(1)); end
    repeat (40) @(negedge clk);
    checks++; if (doneCount - baseDone !== 1 || busy !== 1'b0) begin failures++; $display("FAIL busy_start_ignored: got %0d pulses busy %b want 1 0", doneCount - baseDone, busy); end
    m = 3'($urandom_range(0, 3));
    drive_cmd(m, 3'b000, -1);
    checks++; if (wrLog.size() - baseWr !== 0 || lastDoneCyc - t0 !== OPC + 4) begin failures++; $display("FAIL mask0: got %0d writes done %0d want 0 %0d", wrLog.size() - baseWr, lastDoneCyc - t0, OPC + 4); end
    checks++; if (lastA !== exp_a(int'(m)) || lastB !== exp_b(int'(m))) begin failures++; $display("FAIL mask0_result: got %0d/%0d want %0d/%0d", lastA, lastB, exp_a(int'(m)), exp_b(int'(m))); end
  endtask

  task automatic test_back_to_back();
    fill_random();
    @(negedge clk);
    drive_cmd(3'd0, 3'b001, -1);
    ref_load(3'b001);
    checks++; if (lastDoneCyc - t0 !== 34 || lastA !== exp_a(0)) begin failures++; $display("FAIL b2b_first: got cyc %0d res %0d want 34 %0d", lastDoneCyc - t0, lastA, exp_a(0)); end
    drive_cmd(3'd1, 3'b010, -1);
    ref_load(3'b010);
    checks++; if (lastDoneCyc - t0 !== exp_done(1, 3'b010) || wr_mismatch(3'b010) !== 0) begin failures++; $display("FAIL b2b_second: got cyc %0d want %0d", lastDoneCyc - t0, exp_done(1, 3'b010)); end
    checks++; if (lastA !== exp_a(1) || lastB !== exp_b(1)) begin failures++; $display("FAIL b2b_result: got %0d/%0d want %0d/%0d", lastA, lastB, exp_a(1), exp_b(1)); end
  endtask

  task automatic test_random();
    int mode, bad, nrd;
    logic [2:0] mask;
    for (int it = 0; it < 6; it++) begin
      mode = $urandom_range(0, 3);
      mask = 3'($urandom_range(0, 7));
      fill_random();
      @(negedge clk);
      drive_cmd(3'(mode), mask, -1);
      ref_load(mask);
      bad = wr_mismatch(mask);
      nrd = (mode == 1) ? 2 : 1;
      checks++; if (bad !== 0) begin failures++; $display("FAIL rand_writes[%0d]: got %0d bad want 0 (mode %0d mask %b)", it, bad, mode, mask); end
      checks++; if (lastDoneCyc - t0 !== exp_done(mode, mask)) begin failures++; $display("FAIL rand_done[%0d]: got %0d want %0d", it, lastDoneCyc - t0, exp_done(mode, mask)); end
      checks++; if (lastErr !== 1'b0) begin failures++; $display("FAIL rand_err[%0d]: got %b want 0", it, lastErr); end
      checks++; if (lastA !== exp_a(mode) || lastB !== exp_b(mode)) begin failures++; $display("FAIL rand_result[%0d]: got %0d/%0d want %0d/%0d", it, lastA, lastB, exp_a(mode), exp_b(mode)); end
      checks++; if (opLow - baseOp !== OPC || opModeSeen !== mode) begin failures++; $display("FAIL rand_op[%0d]: got %0d cycles mode %0d want %0d %0d", it, opLow - baseOp, opModeSeen, OPC, mode); end
      checks++; if (rdLog.size() - baseRd !== nrd) begin failures++; $display("FAIL rand_reads[%0d]: got %0d want %0d", it, rdLog.size() - baseRd, nrd); end
      checks++; if (resChg - baseChg !== 0) begin failures++; $display("FAIL rand_result_hold[%0d]: got %0d early changes want 0", it, resChg - baseChg); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    for (int p = 0; p < 3; p++) for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) refRegs[p][r][c] = 8'd0;
    test_reset();
    test_gaussian();
    test_sobel();
    test_hysteresis();
    test_nms();
    test_illegal();
    test_robust();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

endmodule
